// File: rtl/pic_pkg.sv
// Shared constants, opcode encodings and control-flow decode for the PIC16-style fetch path.
package pic_pkg;

  localparam int ADDR_W  = 11;
  localparam int INSTR_W = 14;

  localparam logic [13:0] OP_GOTO_MASK  = 14'h3800;
  localparam logic [13:0] OP_GOTO       = 14'h2800;
  localparam logic [13:0] OP_CALL_MASK  = 14'h3800;
  localparam logic [13:0] OP_CALL       = 14'h2000;
  localparam logic [13:0] OP_RETURN     = 14'h0008;
  localparam logic [13:0] OP_RETLW_MASK = 14'h3C00;
  localparam logic [13:0] OP_RETLW      = 14'h3400;
  localparam logic [13:0] NOP           = 14'h0000;

  typedef enum logic [2:0] {
    CF_NONE,
    CF_GOTO,
    CF_CALL,
    CF_RET,
    CF_RETLW
  } cf_e;

  function automatic cf_e decode_cf(input logic [INSTR_W-1:0] instr);
    cf_e cf;
    cf = CF_NONE;
    if ((instr & OP_GOTO_MASK) == OP_GOTO)         cf = CF_GOTO;
    else if ((instr & OP_CALL_MASK) == OP_CALL)    cf = CF_CALL;
    else if ((instr & OP_RETLW_MASK) == OP_RETLW)  cf = CF_RETLW;
    else if (instr == OP_RETURN)                   cf = CF_RET;
    return cf;
  endfunction

endpackage

// File: rtl/pic_hw_stack.sv
// Circular return-address stack: a push on a full stack overwrites the oldest entry,
// a pop on an empty one still returns the wrapped entry; both raise sticky flags.
module pic_hw_stack #(
  parameter int ADDR_W = 11,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_data,
  output logic [ADDR_W-1:0] pop_data,
  output logic              ovf,
  output logic              unf
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  sp;
  logic [PTR_W-1:0]  sp_m1;
  logic [CNT_W-1:0]  count;

  assign sp_m1    = sp - PTR_ONE;
  assign pop_data = mem[sp_m1];

  always_ff @(posedge clk) begin
    if (push) mem[sp] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sp    <= '0;
      count <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else if (push) begin
      sp <= sp + PTR_ONE;
      // count saturates; the live window slides over the oldest entry
      if (count == CNT_MAX) ovf <= 1'b1;
      else                  count <= count + CNT_ONE;
    end else if (pop) begin
      sp <= sp_m1;
      if (count == '0) unf <= 1'b1;
      else             count <= count - CNT_ONE;
    end
  end

endmodule

// File: rtl/pic_fetch_sequencer.sv
// PC / instruction-register controller for the 2K x 14 program ROM; one-cycle fetch,
// taken branches and skips flush the fetch slot, stall freezes everything.
module pic_fetch_sequencer #(
  parameter int ADDR_W      = pic_pkg::ADDR_W,
  parameter int INSTR_W     = pic_pkg::INSTR_W,
  parameter int STACK_DEPTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [INSTR_W-1:0] rom_data,
  input  logic               stall,
  input  logic               skip,
  output logic [INSTR_W-1:0] ir,
  output logic               ir_valid,
  output logic [ADDR_W-1:0]  ir_pc,
  output logic               retlw_we,
  output logic [7:0]         retlw_lit,
  output logic               stk_ovf,
  output logic               stk_unf
);

  import pic_pkg::*;

  localparam logic [ADDR_W-1:0] PC_ONE = 1;

  logic [ADDR_W-1:0]  pc, pc_nxt, ir_pc_nxt, pop_data;
  logic [INSTR_W-1:0] ir_nxt;
  logic               ir_valid_nxt, retlw_we_nxt, push, pop;
  logic [7:0]         retlw_lit_nxt;
  cf_e                cf;

  assign rom_addr = pc;

  pic_hw_stack #(
    .ADDR_W (ADDR_W),
    .DEPTH  (STACK_DEPTH)
  ) u_stack (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .push_data (pc),
    .pop_data  (pop_data),
    .ovf       (stk_ovf),
    .unf       (stk_unf)
  );

  always_comb begin
    cf            = ir_valid ? decode_cf(ir) : CF_NONE;
    pc_nxt        = pc;
    ir_nxt        = ir;
    ir_valid_nxt  = ir_valid;
    ir_pc_nxt     = ir_pc;
    retlw_we_nxt  = 1'b0;
    retlw_lit_nxt = retlw_lit;
    push          = 1'b0;
    pop           = 1'b0;
    if (!stall) begin
      // control flow in ir wins over skip; every taken branch flushes the fetch slot
      case (cf)
        CF_GOTO: begin
          pc_nxt       = ir[ADDR_W-1:0];
          ir_nxt       = NOP;
          ir_valid_nxt = 1'b0;
        end
        CF_CALL: begin
          push         = 1'b1;
          pc_nxt       = ir[ADDR_W-1:0];
          ir_nxt       = NOP;
          ir_valid_nxt = 1'b0;
        end
        CF_RET: begin
          pop          = 1'b1;
          pc_nxt       = pop_data;
          ir_nxt       = NOP;
          ir_valid_nxt = 1'b0;
        end
        CF_RETLW: begin
          pop           = 1'b1;
          pc_nxt        = pop_data;
          ir_nxt        = NOP;
          ir_valid_nxt  = 1'b0;
          retlw_we_nxt  = 1'b1;
          retlw_lit_nxt = ir[7:0];
        end
        default: begin
          pc_nxt       = pc + PC_ONE;
          ir_pc_nxt    = pc;
          ir_nxt       = skip ? NOP : rom_data;
          ir_valid_nxt = !skip;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= '0;
      ir        <= NOP;
      ir_valid  <= 1'b0;
      ir_pc     <= '0;
      retlw_we  <= 1'b0;
      retlw_lit <= '0;
    end else begin
      pc        <= pc_nxt;
      ir        <= ir_nxt;
      ir_valid  <= ir_valid_nxt;
      ir_pc     <= ir_pc_nxt;
      retlw_we  <= retlw_we_nxt;
      retlw_lit <= retlw_lit_nxt;
    end
  end

endmodule

// File: tb/tb_pic_fetch_sequencer.sv
// Directed bench for pic_fetch_sequencer with a behavioural combinational ROM.
module tb_pic_fetch_sequencer;

  logic        clk;
  logic        rst;
  logic [10:0] rom_addr;
  logic [13:0] rom_data;
  logic        stall;
  logic        skip;
  logic [13:0] ir;
  logic        ir_valid;
  logic [10:0] ir_pc;
  logic        retlw_we;
  logic [7:0]  retlw_lit;
  logic        stk_ovf;
  logic        stk_unf;

  logic [13:0] rom [0:2047];
  int checks = 0;
  int errors = 0;

  assign rom_data = rom[rom_addr];

  pic_fetch_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .stall     (stall),
    .skip      (skip),
    .ir        (ir),
    .ir_valid  (ir_valid),
    .ir_pc     (ir_pc),
    .retlw_we  (retlw_we),
    .retlw_lit (retlw_lit),
    .stk_ovf   (stk_ovf),
    .stk_unf   (stk_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 2048; i++) rom[i] = 14'h0000;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    stall = 1'b1;
    skip  = 1'b0;
    tick();
    stall = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    stall = 1'b0;
    skip  = 1'b0;

    // free-run MOVLW/MOVWF then GOTO 0 at 0x010
    clear_rom();
    for (int i = 0; i < 16; i++) rom[i] = (i % 2 == 0) ? (14'h3000 | 14'(i)) : (14'h0080 | 14'(i));
    rom[16] = 14'h2800;
    do_reset();
    chk("rst_addr",  32'(rom_addr), 32'h0);
    chk("rst_ir",    32'(ir), 32'h0);
    chk("rst_valid", 32'(ir_valid), 32'h0);
    chk("rst_irpc",  32'(ir_pc), 32'h0);
    chk("rst_we",    32'(retlw_we), 32'h0);
    chk("rst_ovf",   32'(stk_ovf), 32'h0);
    chk("rst_unf",   32'(stk_unf), 32'h0);
    for (int i = 0; i <= 16; i++) begin
      chk("seq_addr", 32'(rom_addr), 32'(i));
      tick();
    end
    chk("goto_ir",    32'(ir), 32'h2800);
    chk("goto_irpc",  32'(ir_pc), 32'h10);
    chk("goto_addr",  32'(rom_addr), 32'h11);
    tick();
    chk("goto_flush", 32'(ir_valid), 32'h0);
    chk("goto_tgt",   32'(rom_addr), 32'h0);
    tick();
    chk("goto_ir2",   32'(ir), 32'h3000);
    chk("goto_irpc2", 32'(ir_pc), 32'h0);
    chk("goto_v2",    32'(ir_valid), 32'h1);

    // CALL 0x100 at 0x020, RETLW 0x5A at 0x100
    clear_rom();
    rom[0]      = 14'h2820;
    rom[11'h20] = 14'h2100;
    rom[11'h100] = 14'h345A;
    do_reset();
    tick(); tick(); tick();
    chk("call_ir",   32'(ir), 32'h2100);
    tick();
    chk("call_tgt",  32'(rom_addr), 32'h100);
    chk("call_flush", 32'(ir_valid), 32'h0);
    tick();
    chk("retlw_pre", 32'(retlw_we), 32'h0);
    tick();
    chk("retlw_we",  32'(retlw_we), 32'h1);
    chk("retlw_lit", 32'(retlw_lit), 32'h5A);
    chk("ret_addr",  32'(rom_addr), 32'h21);
    tick();
    chk("retlw_one", 32'(retlw_we), 32'h0);
    chk("ret_irpc",  32'(ir_pc), 32'h21);
    chk("call_ovf",  32'(stk_ovf), 32'h0);
    chk("call_unf",  32'(stk_unf), 32'h0);

    // skip while ir_pc=0x004 squashes the word at 0x005
    clear_rom();
    for (int i = 0; i < 16; i++) rom[i] = 14'h3000 | 14'(i);
    do_reset();
    for (int i = 0; i < 5; i++) tick();
    chk("skip_pre", 32'(ir_pc), 32'h4);
    skip = 1'b1;
    tick();
    skip = 1'b0;
    chk("skip_bubble", 32'(ir_valid), 32'h0);
    chk("skip_addr",   32'(rom_addr), 32'h6);
    tick();
    chk("skip_irpc",   32'(ir_pc), 32'h6);
    chk("skip_ir",     32'(ir), 32'h3006);
    chk("skip_valid",  32'(ir_valid), 32'h1);

    // stall held 3 cycles over GOTO 0x050, with skip noise that must be ignored
    clear_rom();
    rom[0] = 14'h2850;
    do_reset();
    tick();
    stall = 1'b1;
    skip  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_addr",  32'(rom_addr), 32'h1);
      chk("stall_ir",    32'(ir), 32'h2850);
      chk("stall_valid", 32'(ir_valid), 32'h1);
      chk("stall_we",    32'(retlw_we), 32'h0);
    end
    stall = 1'b0;
    tick();
    skip = 1'b0;
    chk("stall_taken", 32'(rom_addr), 32'h50);
    chk("stall_flush", 32'(ir_valid), 32'h0);

    // nine nested CALLs (pushing 0x001,0x011..0x081) then nine RETURNs
    clear_rom();
    for (int j = 0; j < 9; j++) begin
      rom[j*16]     = 14'h2000 | 14'((j + 1) * 16);
      rom[j*16 + 1] = 14'h0008;
    end
    rom[11'h90] = 14'h0008;
    do_reset();
    for (int j = 0; j < 8; j++) begin tick(); tick(); end
    tick();
    chk("ovf_pre", 32'(stk_ovf), 32'h0);
    tick();
    chk("ovf_set",  32'(stk_ovf), 32'h1);
    chk("call9_tgt", 32'(rom_addr), 32'h90);
    for (int k = 0; k < 9; k++) begin
      tick();
      chk("unf_pre", 32'(stk_unf), 32'h0);
      tick();
      chk("ret_seq", 32'(rom_addr), (k < 8) ? 32'(12'h81 - 12'(16 * k)) : 32'h81);
      chk("unf_now", 32'(stk_unf), (k == 8) ? 32'h1 : 32'h0);
    end
    chk("ovf_sticky", 32'(stk_ovf), 32'h1);

    // wrap at top of ROM, then reset during a CALL flush
    clear_rom();
    rom[0]       = 14'h2FFE;
    rom[11'h7FF] = 14'h2300;
    do_reset();
    tick(); tick();
    chk("wrap_7fe", 32'(rom_addr), 32'h7FE);
    tick();
    chk("wrap_7ff", 32'(rom_addr), 32'h7FF);
    tick();
    chk("wrap_000", 32'(rom_addr), 32'h0);
    chk("wrap_irpc", 32'(ir_pc), 32'h7FF);
    tick();
    chk("mid_call", 32'(rom_addr), 32'h300);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_addr",  32'(rom_addr), 32'h0);
    chk("rst_mid_valid", 32'(ir_valid), 32'h0);
    chk("rst_mid_irpc",  32'(ir_pc), 32'h0);
    chk("rst_mid_ovf",   32'(stk_ovf), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
